mux4_share_arbiter: RTL
=======================

Name: mux4_share_arbiter

Overview:
- Round-robin controller that shares one 4:1 gate-level mux among four requesters.
- Drives the mux sel1/sel0 inputs and issues a one-hot grant.
- Waits a programmable settle time so the mux output path (worst case 2+5+5+9+9 = 30 ns) is stable before asserting out_valid.
- Enforces a maximum hold time per grant so no requester can starve the others.

Parameters:
- SETTLE_CYC, 3, cycles between a sel change and out_valid; legal range 1..255; 3 covers 30 ns at a 10 ns clock.
- MAX_HOLD, 16, maximum cycles a grant stays in GRANT; 0 disables the timeout; legal range 0..255.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  4  request per mux input; req[i] maps to in_i; holding it high keeps the grant, dropping it releases
- sel1  output  1  mux select MSB
- sel0  output  1  mux select LSB; {sel1,sel0} = index of the granted requester
- gnt  output  4  one-hot grant; all zero when no grant is active
- out_valid  output  1  high while the mux output is settled for the granted index
- timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD
- busy  output  1  high whenever state != IDLE

Behaviour:
- All outputs are registered.
- Reset (rst_n low, asynchronous):
  - sel1=0, sel0=0, gnt=0000, out_valid=0, timeout=0, busy=0.
  - State IDLE, rotation pointer last=3, so req[0] has first priority.
  - Counters cleared.
  - A reset mid-grant drops everything immediately; no timeout pulse is generated.
- States: IDLE, SETTLE, GRANT.
- IDLE:
  - If req != 0 at a clock edge, pick the first asserted index scanning last+1, last+2, ... modulo 4.
  - At that same edge: sel <= index, gnt <= onehot(index), busy <= 1, settle counter <= SETTLE_CYC-1, go to SETTLE.
  - If req == 0, sel holds its previous value (never forced back to 00, to avoid mux output glitches) and gnt stays 0000.
- SETTLE:
  - out_valid=0.
  - When the counter is 0, go to GRANT with out_valid <= 1 and hold counter <= 0; otherwise decrement.
  - gnt rises to out_valid rises = SETTLE_CYC cycles.
  - If req[g] drops during SETTLE (g = granted index), abort: gnt <= 0, busy <= 0, last <= g, go to IDLE, no timeout.
- GRANT:
  - out_valid=1; the hold counter increments each cycle.
  - Release: on the edge where req[g] is sampled low, gnt <= 0, out_valid <= 0, busy <= 0, last <= g, go to IDLE.
  - Timeout: when MAX_HOLD != 0, the hold counter reaches MAX_HOLD-1, and req[g] is still high, the next edge acts as a release and also sets timeout <= 1 for exactly one cycle.
  - Result: GRANT lasts at most MAX_HOLD cycles.
- Re-arbitration:
  - Every release passes through one IDLE cycle (gnt=0000 for exactly one cycle) before the next grant.
  - Because last=g, the released or timed-out requester has lowest priority next time.
  - If it is the only requester, it is re-granted after the one-cycle gap.
- Other rules:
  - req changes on non-granted indices never affect the current grant.
  - Simultaneous req[g] drop and timeout on the same edge is treated as a release; timeout stays 0.
  - Invariants: at most one gnt bit is high; out_valid implies gnt != 0; gnt != 0 implies {sel1,sel0} = index of the high gnt bit.
  - Counters are 8 bits and never wrap within legal parameter ranges.

Test Plan:
- Reset: hold rst_n=0 with req=1111, then release -> sel=00, gnt=0000, out_valid=0. First edge after release -> gnt=0001; out_valid rises 3 cycles later (SETTLE_CYC=3).
- Rotation: req=1111 held, MAX_HOLD=4 -> grants cycle 0001, 0010, 0100, 1000, 0001. Each grant has 4 GRANT cycles, a timeout pulse at each revocation, and a 1-cycle gnt=0 gap between grants.
- Voluntary release: req=0100 only, drop req[2] after 2 GRANT cycles -> gnt and out_valid fall on that edge, timeout stays 0, sel stays 10 while IDLE.
- Abort in SETTLE: req=0010, drop req[1] one cycle after gnt=0010 -> out_valid never rises, busy falls, next req=0011 grants index 0 first (last=1).
- Async reset mid-GRANT: assert rst_n=0 between clock edges during a grant of index 3 -> gnt=0000, sel=00, out_valid=0 immediately, with no clock edge required.
- MAX_HOLD=0: req=1000 held for 100 cycles -> gnt=1000 continuously and timeout is never asserted.

Source files
------------

// File: rtl/mux4_share_arbiter.sv
// Round-robin owner of a shared 4:1 gate-level mux.
// Drives the selects, waits for the mux path to settle, and bounds hold time.
module mux4_share_arbiter #(
  parameter int SETTLE_CYC = 3,
  parameter int MAX_HOLD   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic       sel1,
  output logic       sel0,
  output logic [3:0] gnt,
  output logic       out_valid,
  output logic       timeout,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    GRANT
  } state_t;

  localparam logic [7:0] SET_INIT  = 8'(SETTLE_CYC - 1);
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  localparam logic       HOLD_EN   = (MAX_HOLD != 0);

  state_t     state, state_n;
  logic [1:0] sel, sel_n;
  logic [1:0] last, last_n;
  logic [1:0] pick;
  logic [7:0] cnt, cnt_n;
  logic [3:0] gnt_n;
  logic       ov_n, to_n, busy_n;
  logic       own_req;

  assign sel1    = sel[1];
  assign sel0    = sel[0];
  assign own_req = req[sel];

  // Rotating priority: nearest asserted index after last wins.
  always_comb begin
    pick = last;
    for (int k = 4; k >= 1; k--) begin
      if (req[last + 2'(k)]) pick = last + 2'(k);
    end
  end

  // Next-state and registered-output values.
  always_comb begin
    state_n = state;
    sel_n   = sel;
    last_n  = last;
    cnt_n   = cnt;
    gnt_n   = gnt;
    ov_n    = out_valid;
    to_n    = 1'b0;
    busy_n  = busy;
    unique case (state)
      IDLE: begin
        if (req != 4'b0000) begin
          sel_n   = pick;
          gnt_n   = 4'b0001 << pick;
          busy_n  = 1'b1;
          cnt_n   = SET_INIT;
          state_n = SETTLE;
        end
      end
      SETTLE: begin
        ov_n = 1'b0;
        if (!own_req) begin
          gnt_n   = 4'b0000;
          busy_n  = 1'b0;
          last_n  = sel;
          state_n = IDLE;
        end else if (cnt == 8'd0) begin
          ov_n    = 1'b1;
          cnt_n   = 8'd0;
          state_n = GRANT;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      GRANT: begin
        if (!own_req || (HOLD_EN && cnt == HOLD_LAST)) begin
          to_n    = own_req;
          gnt_n   = 4'b0000;
          ov_n    = 1'b0;
          busy_n  = 1'b0;
          last_n  = sel;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      default: begin
        gnt_n   = 4'b0000;
        ov_n    = 1'b0;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any grant at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel       <= 2'b00;
      last      <= 2'd3;
      cnt       <= 8'd0;
      gnt       <= 4'b0000;
      out_valid <= 1'b0;
      timeout   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      sel       <= sel_n;
      last      <= last_n;
      cnt       <= cnt_n;
      gnt       <= gnt_n;
      out_valid <= ov_n;
      timeout   <= to_n;
      busy      <= busy_n;
    end
  end

endmodule
